lfb_dual_alloc_ctrl: RTL and testbench

LFB_DUAL_ALLOC_CTRL -- requirements
Module: lfb_dual_alloc_ctrl

---
 rtl/lfb_dual_alloc_ctrl.sv | 117 +++++++++++
 tb/tb_lfb_dual_alloc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfb_dual_alloc_ctrl.sv
// Dual-port line-fill buffer entry allocator with single release port.
// Port0 takes the lowest FREE entry, port1 the highest distinct FREE entry.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush_i            free every entry (highest priority)
//   alloc_vld_i[1:0]   per-port allocation request
//   alloc_rdy_o[1:0]   per-port grant (combinational from registered state)
//   alloc_id0_o/1_o    granted entry ids
//   rel_vld_i/rel_id_i release request and target id
//   rel_err_o          registered pulse for an illegal release
//   free_cnt_o         registered free-entry count
//   full_o / empty_o   no entry free / all entries free
module lfb_dual_alloc_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int ID_W      = $clog2(ENTRY_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [1:0]      alloc_vld_i,
    output logic [1:0]      alloc_rdy_o,
    output logic [ID_W-1:0] alloc_id0_o,
    output logic [ID_W-1:0] alloc_id1_o,
    input  logic            rel_vld_i,
    input  logic [ID_W-1:0] rel_id_i,
    output logic            rel_err_o,
    output logic [ID_W:0]   free_cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [ENTRY_NUM-1:0] r_free_q;
    logic [ID_W:0]        r_free_cnt;
    logic                 r_rel_err;

    logic [ENTRY_NUM-1:0] w_free_nxt;
    logic [ID_W:0]        w_cnt_nxt;
    logic [ID_W-1:0]      w_lo_id;
    logic [ID_W-1:0]      w_hi_id;
    logic                 w_any_free;
    logic                 w_xfer0;
    logic                 w_xfer1;
    logic                 w_rel_ok;
    logic                 w_rel_in_rng;
    logic                 w_gate;

    // Lowest and highest FREE index, from registered state only, so a
    // release never feeds back into the same-cycle grant.
    always_comb begin
        w_lo_id    = '0;
        w_hi_id    = '0;
        w_any_free = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (r_free_q[i]) begin
                w_lo_id = ID_W'(i);
            end
        end
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (r_free_q[i]) begin
                w_hi_id    = ID_W'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign w_gate  = !rst && !flush_i;
    assign w_xfer0 = w_gate && alloc_vld_i[0] && w_any_free;
    // With two or more FREE entries lo != hi, so only the single-entry
    // case needs to yield to port0.
    assign w_xfer1 = w_gate && alloc_vld_i[1] && w_any_free &&
                     !(w_xfer0 && (w_lo_id == w_hi_id));

    assign w_rel_in_rng = int'(rel_id_i) < ENTRY_NUM;
    assign w_rel_ok     = rel_vld_i && w_rel_in_rng &&
                          !r_free_q[rel_id_i];

    always_comb begin
        w_free_nxt = r_free_q;
        if (w_xfer0) begin
            w_free_nxt[w_lo_id] = 1'b0;
        end
        if (w_xfer1) begin
            w_free_nxt[w_hi_id] = 1'b0;
        end
        // A legal release targets a BUSY entry, which can never be one
        // of the FREE entries granted this cycle.
        if (w_rel_ok) begin
            w_free_nxt[rel_id_i] = 1'b1;
        end
        w_cnt_nxt = r_free_cnt
                  + (ID_W+1)'(w_rel_ok)
                  - (ID_W+1)'(w_xfer0)
                  - (ID_W+1)'(w_xfer1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_free_q   <= '1;
            r_free_cnt <= (ID_W+1)'(ENTRY_NUM);
            r_rel_err  <= 1'b0;
        end else begin
            r_free_q   <= w_free_nxt;
            r_free_cnt <= w_cnt_nxt;
            r_rel_err  <= rel_vld_i && !w_rel_ok;
        end
    end

    assign alloc_rdy_o = {w_xfer1, w_xfer0};
    assign alloc_id0_o = w_lo_id;
    assign alloc_id1_o = w_hi_id;
    assign rel_err_o   = r_rel_err;
    assign free_cnt_o  = r_free_cnt;
    assign full_o      = (r_free_cnt == '0);
    assign empty_o     = (r_free_cnt == (ID_W+1)'(ENTRY_NUM));

endmodule

// File: tb/tb_lfb_dual_alloc_ctrl.sv
// Testbench for lfb_dual_alloc_ctrl: entry-set model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lfb_dual_alloc_ctrl;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic [1:0]   alloc_vld_i;
    logic [1:0]   alloc_rdy_o;
    logic [W-1:0] alloc_id0_o;
    logic [W-1:0] alloc_id1_o;
    logic         rel_vld_i;
    logic [W-1:0] rel_id_i;
    logic         rel_err_o;
    logic [W:0]   free_cnt_o;
    logic         full_o;
    logic         empty_o;

    lfb_dual_alloc_ctrl #(.ENTRY_NUM(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .alloc_vld_i (alloc_vld_i),
        .alloc_rdy_o (alloc_rdy_o),
        .alloc_id0_o (alloc_id0_o),
        .alloc_id1_o (alloc_id1_o),
        .rel_vld_i   (rel_vld_i),
        .rel_id_i    (rel_id_i),
        .rel_err_o   (rel_err_o),
        .free_cnt_o  (free_cnt_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    bit       m_free [N];
    bit       m_err;
    bit       chk_en;
    int       n_chk;
    int       n_fail;
    logic [1:0] e_rdy;
    int       e_id0;
    int       e_id1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int nfree();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_free[i]);
        return c;
    endfunction

    // Port0 gets the smallest free index; port1 gets the largest free
    // index not already handed to port0.
    task automatic predict();
        bit found = 0;
        e_rdy = 2'b00;
        e_id0 = 0;
        e_id1 = 0;
        for (int i = N - 1; i >= 0; i--) if (m_free[i]) e_id0 = i;
        e_rdy[0] = !rst && !flush_i && alloc_vld_i[0] && (nfree() > 0);
        for (int i = 0; i < N; i++) begin
            if (m_free[i] && !(e_rdy[0] && i == e_id0)) begin
                e_id1 = i;
                found = 1;
            end
        end
        e_rdy[1] = !rst && !flush_i && alloc_vld_i[1] && found;
    endtask

    always @(posedge clk) begin
        bit legal;
        predict();
        if (rst || flush_i) begin
            for (int i = 0; i < N; i++) m_free[i] = 1'b1;
            m_err = 1'b0;
        end else begin
            legal = rel_vld_i && (int'(rel_id_i) < N) && !m_free[rel_id_i];
            m_err = rel_vld_i && !legal;
            if (e_rdy[0]) m_free[e_id0] = 1'b0;
            if (e_rdy[1]) m_free[e_id1] = 1'b0;
            if (legal) m_free[rel_id_i] = 1'b1;
        end
        if (rst) chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            predict();
            chk("m_rdy", alloc_rdy_o, e_rdy);
            if (e_rdy[0] && alloc_rdy_o[0]) chk("m_id0", alloc_id0_o, e_id0);
            if (e_rdy[1] && alloc_rdy_o[1]) chk("m_id1", alloc_id1_o, e_id1);
            chk("m_cnt", free_cnt_o, nfree());
            chk("m_full", full_o, nfree() == 0);
            chk("m_empty", empty_o, nfree() == N);
            chk("m_err", rel_err_o, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        alloc_vld_i = 2'b11;
        rel_vld_i = 1'b0;
        rel_id_i = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_rdy", alloc_rdy_o, 2'b00);
        chk("rst_cnt", free_cnt_o, 8);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_err", rel_err_o, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_rdy", alloc_rdy_o, 2'b11);
            chk("seq_id0", alloc_id0_o, k);
            chk("seq_id1", alloc_id1_o, 7 - k);
            if (k == 1) chk("seq_cnt6", free_cnt_o, 6);
            tick();
        end
        @(negedge clk);
        chk("full_flag", full_o, 1);
        chk("full_rdy", alloc_rdy_o, 2'b00);
        tick();
        alloc_vld_i = 2'b01;
        rel_vld_i = 1'b1;
        rel_id_i = 3'd5;
        @(negedge clk);
        chk("relcyc_rdy0", alloc_rdy_o[0], 0);
        tick();
        rel_vld_i = 1'b0;
        @(negedge clk);
        chk("reuse_rdy0", alloc_rdy_o[0], 1);
        chk("reuse_id0", alloc_id0_o, 5);
        chk("reuse_cnt", free_cnt_o, 1);
        tick();
        alloc_vld_i = 2'b00;
        rel_vld_i = 1'b1;
        rel_id_i = 3'd3;
        tick();
        rel_vld_i = 1'b0;
        alloc_vld_i = 2'b11;
        @(negedge clk);
        chk("one_both_rdy", alloc_rdy_o, 2'b01);
        chk("one_both_id0", alloc_id0_o, 3);
        tick();
        alloc_vld_i = 2'b00;
        rel_vld_i = 1'b1;
        tick();
        rel_vld_i = 1'b0;
        alloc_vld_i = 2'b10;
        @(negedge clk);
        chk("one_p1_rdy", alloc_rdy_o, 2'b10);
        chk("one_p1_id1", alloc_id1_o, 3);
        tick();
        alloc_vld_i = 2'b00;
        rel_vld_i = 1'b1;
        rel_id_i = 3'd2;
        tick();
        tick();
        rel_vld_i = 1'b0;
        @(negedge clk);
        chk("bad_rel_err", rel_err_o, 1);
        chk("bad_rel_cnt", free_cnt_o, 1);
        tick();
        alloc_vld_i = 2'b01;
        rel_vld_i = 1'b1;
        rel_id_i = 3'd4;
        @(negedge clk);
        chk("bad_rel_pulse", rel_err_o, 0);
        chk("both_rdy", alloc_rdy_o, 2'b01);
        chk("both_id0", alloc_id0_o, 2);
        tick();
        alloc_vld_i = 2'b00;
        rel_id_i = 3'd0;
        tick();
        flush_i = 1'b1;
        alloc_vld_i = 2'b11;
        rel_id_i = 3'd1;
        @(negedge clk);
        chk("flush_cnt_pre", free_cnt_o, 2);
        chk("flush_rdy", alloc_rdy_o, 2'b00);
        tick();
        flush_i = 1'b0;
        alloc_vld_i = 2'b00;
        rel_vld_i = 1'b0;
        @(negedge clk);
        chk("flush_cnt", free_cnt_o, 8);
        chk("flush_empty", empty_o, 1);
        chk("flush_err", rel_err_o, 0);
        alloc_vld_i = 2'b11;
        tick();
        tick();
        alloc_vld_i = 2'b00;
        rst = 1'b1;
        rel_vld_i = 1'b1;
        rel_id_i = 3'd3;
        tick();
        rst = 1'b0;
        rel_vld_i = 1'b0;
        @(negedge clk);
        chk("midrst_cnt", free_cnt_o, 8);
        chk("midrst_err", rel_err_o, 0);
        tick();
        for (int c = 0; c < 300; c++) begin
            alloc_vld_i = 2'($urandom);
            rel_vld_i = 1'($urandom);
            rel_id_i = 3'($urandom);
            flush_i = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
